// File: rtl/scan_sequencer_pkg.sv
// Common game constants: board geometry, cell encodings and RAM field widths,
// plus the sequencer state encoding.
package scan_sequencer_pkg;

  localparam int BRD_DIM   = 19;
  localparam int BRD_CELLS = BRD_DIM * BRD_DIM;
  localparam int COORD_W   = 5;
  localparam int WT_W      = 4;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    WHITE = 2'd1,
    EMPTY = 2'd2
  } cell_t;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [WT_W-1:0]    wt_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    GUARD  = 3'd3,
    WAIT   = 3'd4,
    NEXT   = 3'd5,
    DONE   = 3'd6
  } seq_state_t;

endpackage

// File: rtl/scan_sequencer_if.sv
// Scanner-bank and RAM-port bundle between the sequencer (master) and the
// scanners / board RAM / weight RAM (slave). Scanner k owns slice k of each bus.
interface scan_sequencer_if #(
  parameter int NUM_SCAN = 4
);
  import scan_sequencer_pkg::*;

  logic                        scan_colour;
  logic [NUM_SCAN-1:0]         scan_ena;
  logic [NUM_SCAN-1:0]         scan_done;
  logic [NUM_SCAN-1:0]         scan_rd_en;
  logic [NUM_SCAN*COORD_W-1:0] scan_x;
  logic [NUM_SCAN*COORD_W-1:0] scan_y;
  logic [NUM_SCAN-1:0]         scan_we;
  logic [NUM_SCAN*WT_W-1:0]    scan_wt;

  logic                        brd_rd_en;
  coord_t                      brd_x;
  coord_t                      brd_y;
  logic                        wt_we;
  coord_t                      wt_x;
  coord_t                      wt_y;
  wt_t                         wt_data;

  modport master (
    output scan_colour, scan_ena, brd_rd_en, brd_x, brd_y,
           wt_we, wt_x, wt_y, wt_data,
    input  scan_done, scan_rd_en, scan_x, scan_y, scan_we, scan_wt
  );

  modport slave (
    input  scan_colour, scan_ena, brd_rd_en, brd_x, brd_y,
           wt_we, wt_x, wt_y, wt_data,
    output scan_done, scan_rd_en, scan_x, scan_y, scan_we, scan_wt
  );

endinterface

// File: rtl/scan_sequencer_port_mux.sv
// Forwards the selected scanner's board-read and weight-write requests;
// all outputs are 0 unless en, so idle scanners can never reach the RAMs.
module scan_port_mux import scan_sequencer_pkg::*; #(
  parameter int NUM_SCAN = 4,
  parameter int KW       = 2
) (
  input  logic                             en,
  input  logic [KW-1:0]                    sel,
  input  logic [NUM_SCAN-1:0]              rdEn,
  input  logic [NUM_SCAN-1:0]              we,
  input  logic [NUM_SCAN-1:0][COORD_W-1:0] xs,
  input  logic [NUM_SCAN-1:0][COORD_W-1:0] ys,
  input  logic [NUM_SCAN-1:0][WT_W-1:0]    wts,
  output logic                             selRdEn,
  output logic                             selWe,
  output coord_t                           selX,
  output coord_t                           selY,
  output wt_t                              selWt
);

  always_comb begin
    selRdEn = 1'b0;
    selWe   = 1'b0;
    selX    = '0;
    selY    = '0;
    selWt   = '0;
    for (int i = 0; i < NUM_SCAN; i++) begin
      if (en && sel == KW'(i)) begin
        selRdEn = rdEn[i];
        selWe   = we[i];
        selX    = xs[i];
        selY    = ys[i];
        selWt   = wts[i];
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Per-move evaluation controller: clears the weight RAM, then launches each
// line scanner in turn and lends it the shared board-read / weight-write ports.
module scan_sequencer import scan_sequencer_pkg::*; #(
  parameter int NUM_SCAN    = 4,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             colour,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  scan_sequencer_if.master bus
);

  localparam int KW = (NUM_SCAN > 1) ? $clog2(NUM_SCAN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  seq_state_t          state, stateNxt;
  logic [KW-1:0]       k;
  logic [TW-1:0]       toCnt;
  coord_t              cx, cy;
  logic                colourQ;
  logic                scanDoneK, toHit, lastCell, lastScan, clearing, fwdEn;
  logic                selRdEn, selWe;
  coord_t              selX, selY;
  wt_t                 selWt;
  logic [NUM_SCAN-1:0] oneHot;

  assign scanDoneK = bus.scan_done[k];
  assign toHit     = (toCnt == TW'(TIMEOUT_CYC - 1));
  assign lastCell  = (cx == COORD_W'(BRD_DIM - 1)) && (cy == COORD_W'(BRD_DIM - 1));
  assign lastScan  = (k == KW'(NUM_SCAN - 1));
  assign clearing  = (state == CLEAR);
  assign fwdEn     = (state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      toCnt       <= '0;
      cx          <= '0;
      cy          <= '0;
      colourQ     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= stateNxt;
      case (state)
        IDLE: if (start) begin
          colourQ     <= colour;
          err_timeout <= 1'b0;
          busy        <= 1'b1;
          cx          <= '0;
          cy          <= '0;
          k           <= '0;
        end
        CLEAR: begin
          if (cx == COORD_W'(BRD_DIM - 1)) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        LAUNCH: toCnt <= '0;
        WAIT: begin
          toCnt <= toCnt + 1'b1;
          // A done seen on the timeout cycle is a real finish, not an error.
          if (!scanDoneK && toHit) err_timeout <= 1'b1;
        end
        NEXT: if (!lastScan) k <= k + 1'b1;
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (start) stateNxt = CLEAR;
      CLEAR:   if (lastCell) stateNxt = LAUNCH;
      LAUNCH:  stateNxt = GUARD;
      // Scanner still shows the previous run's done here.
      GUARD:   stateNxt = WAIT;
      WAIT:    if (scanDoneK || toHit) stateNxt = NEXT;
      NEXT:    stateNxt = lastScan ? DONE : LAUNCH;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  scan_port_mux #(
    .NUM_SCAN (NUM_SCAN),
    .KW       (KW)
  ) uMux (
    .en      (fwdEn),
    .sel     (k),
    .rdEn    (bus.scan_rd_en),
    .we      (bus.scan_we),
    .xs      (bus.scan_x),
    .ys      (bus.scan_y),
    .wts     (bus.scan_wt),
    .selRdEn (selRdEn),
    .selWe   (selWe),
    .selX    (selX),
    .selY    (selY),
    .selWt   (selWt)
  );

  assign oneHot = {{(NUM_SCAN-1){1'b0}}, 1'b1} << k;

  assign done            = (state == DONE);
  assign bus.scan_ena    = (state == LAUNCH) ? oneHot : '0;
  assign bus.scan_colour = colourQ;
  assign bus.brd_rd_en   = selRdEn;
  assign bus.brd_x       = selX;
  assign bus.brd_y       = selY;
  assign bus.wt_we       = clearing | selWe;
  assign bus.wt_x        = clearing ? cx : selX;
  assign bus.wt_y        = clearing ? cy : selY;
  assign bus.wt_data     = clearing ? '0 : selWt;

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Controller that runs one full board evaluation per move.
- Sequence: clear the weight RAM, then run each line scanner (horizontal, vertical, two diagonals) one at a time.
- Shares the single board-RAM read port and the single weight-RAM write port between the scanners.
- Sits between the move/game controller (start/done) and the scanner bank; the move selector reads the weight RAM afterwards.

Parameters:
- NUM_SCAN, 4, number of scanner instances sequenced, in index order 0..NUM_SCAN-1.
- BRD_DIM, 19, board width and height in cells.
- TIMEOUT_CYC, 4095, maximum WAIT cycles per scanner before it is abandoned.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin an evaluation
- colour  in  1  FPGA colour (0 black, 1 white); latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of evaluation
- err_timeout  out  1  sticky; set when any scanner times out, cleared on accepted start
- scan_colour  out  1  latched colour, driven to all scanners
- scan_ena  out  NUM_SCAN  one-hot launch pulse per scanner
- scan_done  in  NUM_SCAN  per-scanner done level
- scan_rd_en  in  NUM_SCAN  per-scanner board read request
- scan_x, scan_y  in  5*NUM_SCAN  packed read/write coordinates, scanner k at bits [5k+4:5k]
- scan_we  in  NUM_SCAN  per-scanner weight write request
- scan_wt  in  4*NUM_SCAN  packed weight data
- brd_rd_en  out  1  board RAM read enable
- brd_x, brd_y  out  5  board RAM address
- wt_we  out  1  weight RAM write enable
- wt_x, wt_y  out  5  weight RAM address
- wt_data  out  4  weight RAM write data

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-evaluation aborts immediately; no done pulse is issued.

IDLE:
- On start: latch colour, clear err_timeout, busy<=1, cx<=0, cy<=0, go to CLEAR.
- start is ignored while busy.

CLEAR:
- One write per cycle: wt_we=1, wt_x=cx, wt_y=cy, wt_data=0.
- cx increments; at cx=BRD_DIM-1, cx<=0 and cy increments.
- After writing (BRD_DIM-1, BRD_DIM-1) → LAUNCH with k=0. Exactly 361 write cycles.

LAUNCH:
- scan_ena[k]=1 for exactly this one cycle; timeout counter<=0. Next state GUARD.

GUARD:
- One cycle; scan_done[k] is ignored, because the scanner still shows its stale done. Next state WAIT.

WAIT:
- Combinationally forward scanner k: brd_rd_en=scan_rd_en[k], wt_we=scan_we[k], wt_data=scan_wt[k].
- Board and weight address come from scanner k's x/y.
- Requests from non-selected scanners are ignored; their outputs are masked to 0.
- On scan_done[k]=1 → NEXT.
- If the counter reaches TIMEOUT_CYC first: err_timeout<=1, then → NEXT.

NEXT:
- If k=NUM_SCAN-1 → DONE; else k<=k+1 → LAUNCH.
- Forwarding is off in this state.

DONE:
- done=1 for one cycle, busy<=0 → IDLE.

Outside CLEAR and WAIT: brd_rd_en=0, wt_we=0, addresses/data 0.

Simultaneous events:
- Done and timeout in the same WAIT cycle: done wins, no error.
- start arriving in the same cycle as the done pulse is ignored.

Widths and latency:
- k is clog2(NUM_SCAN) bits; timeout counter is clog2(TIMEOUT_CYC+1) bits.
- Latency from start to done = 1 + 361 + sum over scanners of (3 + wait cycles) + 1.

Decomposition:
- Shared package (the game's common constants package):
  - BRD_DIM
  - cell encodings BLACK=0, WHITE=1, EMPTY=2
  - weight width 4
  - coordinate width 5
- One natural sub-module: scan_port_mux, a combinational one-hot select of scanner k's read/write buses with masking. Everything else stays in the FSM.

Test Plan:
- Clear sweep: start with no scanners responding, scan_done=0, TIMEOUT_CYC=15 → exactly 361 wt_we cycles covering (0,0)..(18,18) with data 0, then four timeouts, err_timeout=1, one done pulse.
- Normal run: scanner models that assert done 100 cycles after ena → scan_ena pulses in order 0,1,2,3, each one cycle wide; done arrives 1+361+4*(3+100)+1 cycles after start; err_timeout=0.
- Stale done: scan_done[k] held at 1 before launch, deasserted the cycle after ena → sequencer does not advance during GUARD and waits for the real done.
- Port isolation: during scanner 1's WAIT, scanner 2 drives we=1, x=7, y=7, wt=9 → wt_we follows scanner 1 only; no write ever appears at (7,7) with data 9.
- Restart rules: start pulsed during WAIT → ignored. colour=1 latched at start, then colour changed to 0 → scan_colour stays 1 until the next start.
- Reset mid-CLEAR at cell (5,3) → all outputs 0 immediately, no done; a fresh start clears again from (0,0).
